// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, Booth step codes,
// default sizing.
package mdu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MULT    = 2'd1,
        DIV     = 2'd2,
        DIV_FIX = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the {Q0, Q-1} pair.
    function automatic booth_op_t booth_decode(input logic [1:0] q_pair);
        case (q_pair)
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend
// bit, trial-subtract the divisor, keep or restore.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;
    logic           w_qbit;

    // The quotient register doubles as the dividend shifter; its MSB feeds the remainder.
    assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, i_dvs};
    assign w_qbit   = ~w_diff[WIDTH];
    assign o_rem    = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign o_quo    = {i_quo[WIDTH-2:0], w_qbit};

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit writing
// the HI/LO registers; one iteration per clock.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    booth_op_t          w_bop;
    logic [WIDTH:0]     w_a_ext;
    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic               w_last;

    // The add/sub runs one bit wider so the most-negative multiplicand cannot overflow A.
    assign w_bop   = booth_decode(r_acc[1:0]);
    assign w_a_ext = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
    assign w_m_ext = {r_mcand[WIDTH-1], r_mcand};

    always_comb begin
        w_sum = w_a_ext;
        case (w_bop)
            BOOTH_ADD: w_sum = w_a_ext + w_m_ext;
            BOOTH_SUB: w_sum = w_a_ext - w_m_ext;
            default:   w_sum = w_a_ext;
        endcase
    end

    // Arithmetic shift right folded into the concatenation: sum bit 0 drops into Q.
    assign w_acc_nxt = {w_sum, r_acc[WIDTH:1]};

    assign w_abs_a = a_in[WIDTH-1] ? -a_in : a_in;
    assign w_abs_b = b_in[WIDTH-1] ? -b_in : b_in;
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_mult) begin
                        r_acc   <= {{WIDTH{1'b0}}, b_in, 1'b0};
                        r_mcand <= a_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MULT;
                    end else if (start_div) begin
                        if (b_in == '0) begin
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_abs_a;
                            r_dvs   <= w_abs_b;
                            r_q_neg <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            r_r_neg <= a_in[WIDTH-1];
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= DIV;
                        end
                    end
                end
                MULT: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi    <= w_acc_nxt[2*WIDTH:WIDTH+1];
                        r_lo    <= w_acc_nxt[WIDTH:1];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) r_state <= DIV_FIX;
                end
                DIV_FIX: begin
                    r_lo    <= r_q_neg ? -r_quo : r_quo;
                    r_hi    <= r_r_neg ? -r_rem : r_rem;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hi_out   = r_hi;
    assign lo_out   = r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a plain-arithmetic
// signed multiply/divide model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a_in       (a_in),
        .b_in       (b_in),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    // Returns {remainder, quotient}; SV signed division truncates toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] qv, rv;
        x  = longint'($signed(a));
        y  = longint'($signed(b));
        q  = x / y;
        r  = x % y;
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
    endfunction

    // Call at a posedge+1 point; returns once done is seen (or the bound expires).
    task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt, output logic dz);
        start_mult = m;
        start_div  = d;
        a_in       = a;
        b_in       = b;
        step(1);
        start_mult = 1'b0;
        start_div  = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            busy_cnt += int'(busy);
            step(1);
            lat++;
        end
        dz = div_zero;
    endtask

    int          lat, bc, ndone;
    logic        dz;
    logic [31:0] m_hi, m_lo, sav_hi, sav_lo, ra, rb;
    logic [63:0] r64;
    int          kind;

    initial begin
        step(2);
        chk("reset_hi", hi_out, 32'h0);
        chk("reset_lo", lo_out, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_dz", 32'(div_zero), 32'h0);
        reset = 1'b1;
        step(1);

        // 1: 7 * -3
        do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, bc, dz);
        chk("t1_lat", 32'(lat), 32'd32);
        chk("t1_busy_cycles", 32'(bc), 32'd32);
        chk("t1_busy_at_done", 32'(busy), 32'h0);
        chk("t1_hi", hi_out, 32'hFFFF_FFFF);
        chk("t1_lo", lo_out, 32'hFFFF_FFEB);
        chk("t1_dz", 32'(dz), 32'h0);
        step(1);
        chk("t1_done_one_cycle", 32'(done), 32'h0);

        // 2: most-negative squared, then back-to-back start in the done cycle
        do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat, bc, dz);
        chk("t2a_lat", 32'(lat), 32'd32);
        chk("t2a_hi", hi_out, 32'h4000_0000);
        chk("t2a_lo", lo_out, 32'h0);
        do_op(1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, lat, bc, dz);
        chk("t2b_lat", 32'(lat), 32'd32);
        chk("t2b_hi", hi_out, 32'h0);
        chk("t2b_lo", lo_out, 32'hFFFE_0001);

        // 3: signed division, truncation toward zero
        do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc, dz);
        chk("t3a_lat", 32'(lat), 32'd33);
        chk("t3a_busy_cycles", 32'(bc), 32'd33);
        chk("t3a_lo", lo_out, 32'hFFFF_FFFD);
        chk("t3a_hi", hi_out, 32'hFFFF_FFFF);
        chk("t3a_dz", 32'(dz), 32'h0);
        do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, bc, dz);
        chk("t3b_lat", 32'(lat), 32'd33);
        chk("t3b_lo", lo_out, 32'hFFFF_FFFD);
        chk("t3b_hi", hi_out, 32'd1);
        step(1);

        // 4: divide by zero keeps HI/LO, never busy
        sav_hi = hi_out;
        sav_lo = lo_out;
        do_op(1'b0, 1'b1, 32'd5, 32'd0, lat, bc, dz);
        chk("t4_lat", 32'(lat), 32'd0);
        chk("t4_busy_cycles", 32'(bc), 32'd0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_dz", 32'(dz), 32'h1);
        chk("t4_hi_kept", hi_out, sav_hi);
        chk("t4_lo_kept", lo_out, sav_lo);
        step(1);
        chk("t4_done_drop", 32'(done), 32'h0);
        chk("t4_dz_drop", 32'(div_zero), 32'h0);

        // 5: overflow division, then simultaneous starts
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz);
        chk("t5a_lat", 32'(lat), 32'd33);
        chk("t5a_lo", lo_out, 32'h8000_0000);
        chk("t5a_hi", hi_out, 32'h0);
        step(1);
        do_op(1'b1, 1'b1, 32'd100, 32'd7, lat, bc, dz);
        chk("t5b_lat", 32'(lat), 32'd32);
        chk("t5b_hi", hi_out, 32'h0);
        chk("t5b_lo", lo_out, 32'd700);
        ndone = 0;
        repeat (40) begin
            step(1);
            ndone += int'(done);
        end
        chk("t5b_single_done", 32'(ndone), 32'd0);

        // 6: start ignored while busy, then reset aborts the op
        sav_hi     = hi_out;
        sav_lo     = lo_out;
        start_mult = 1'b1;
        a_in       = 32'd3;
        b_in       = 32'd5;
        step(1);
        start_mult = 1'b0;
        step(4);
        start_div  = 1'b1;
        a_in       = 32'd9;
        b_in       = 32'd0;
        step(1);
        start_div  = 1'b0;
        chk("t6_busy_mid", 32'(busy), 32'h1);
        chk("t6_done_mid", 32'(done), 32'h0);
        chk("t6_dz_mid", 32'(div_zero), 32'h0);
        chk("t6_hi_mid", hi_out, sav_hi);
        chk("t6_lo_mid", lo_out, sav_lo);
        step(4);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_hi", hi_out, 32'h0);
        chk("t6_rst_lo", lo_out, 32'h0);
        step(2);
        reset = 1'b1;
        ndone = int'(done);
        repeat (40) begin
            step(1);
            ndone += int'(done);
        end
        chk("t6_no_done", 32'(ndone), 32'd0);
        do_op(1'b1, 1'b0, 32'hFFFF_FFF0, 32'd16, lat, bc, dz);
        chk("t6_fresh_lat", 32'(lat), 32'd32);
        chk("t6_fresh_hi", hi_out, 32'hFFFF_FFFF);
        chk("t6_fresh_lo", lo_out, 32'hFFFF_FF00);

        // Randomized ops against the arithmetic model
        m_hi = hi_out;
        m_lo = lo_out;
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 2));
            ra   = $urandom;
            rb   = $urandom;
            if (i % 6 == 0) ra = 32'h8000_0000;
            if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
            if (kind == 2) rb = 32'd0;
            if (kind == 0) begin
                r64 = ref_mult(ra, rb);
                do_op(1'b1, 1'b0, ra, rb, lat, bc, dz);
                chk("rnd_mul_lat", 32'(lat), 32'd32);
                m_hi = r64[63:32];
                m_lo = r64[31:0];
            end else if (rb != 32'd0) begin
                r64 = ref_div(ra, rb);
                do_op(1'b0, 1'b1, ra, rb, lat, bc, dz);
                chk("rnd_div_lat", 32'(lat), 32'd33);
                m_hi = r64[63:32];
                m_lo = r64[31:0];
            end else begin
                do_op(1'b0, 1'b1, ra, rb, lat, bc, dz);
                chk("rnd_dz_lat", 32'(lat), 32'd0);
            end
            chk("rnd_dz", 32'(dz), ((kind != 0) && (rb == 32'd0)) ? 32'h1 : 32'h0);
            chk("rnd_hi", hi_out, m_hi);
            chk("rnd_lo", lo_out, m_lo);
            if (i % 3 == 0) step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
